// File: rtl/cpu_run_ctrl_pkg.sv
// Shared encodings for the cpu run/step sequencer: debug opcodes, stop causes, FSM states.
package cpu_run_ctrl_pkg;

  localparam int REG_W = 32;

  typedef enum logic [2:0] {
    CMD_NOP       = 3'd0,
    CMD_RUN       = 3'd1,
    CMD_STEP      = 3'd2,
    CMD_STOP      = 3'd3,
    CMD_RESET_CPU = 3'd4,
    CMD_SET_BP    = 3'd5,
    CMD_CLR_BP    = 3'd6
  } cmd_op_e;

  typedef enum logic [2:0] {
    STOP_NONE      = 3'd0,
    STOP_HALT      = 3'd1,
    STOP_BREAK     = 3'd2,
    STOP_USER      = 3'd3,
    STOP_TIMEOUT   = 3'd4,
    STOP_STEP_DONE = 3'd5
  } stop_cause_e;

  typedef enum logic [1:0] {
    CTRL_IDLE    = 2'd0,
    CTRL_RUN     = 2'd1,
    CTRL_STEP    = 2'd2,
    CTRL_CPU_RST = 2'd3
  } ctrl_state_e;

  // A STEP of zero still executes one instruction.
  function automatic logic [REG_W-1:0] step_count(input logic [REG_W-1:0] arg);
    return (arg == '0) ? REG_W'(1) : arg;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step sequencer for the single-cycle cpu: owns cpu clock-enable and cpu reset,
// executes debug commands and reports why execution stopped.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int CYC_W      = 32,
  parameter int TIMEOUT    = 1000,
  parameter int RST_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  // Handshake: a command is consumed on every cycle with cmd_valid && cmd_ready;
  // cmd_ready only drops while the cpu is being held in reset.
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [REG_W-1:0] cmd_arg,
  input  logic             cpu_halted,
  input  logic [REG_W-1:0] cpu_pc,
  output logic             cpu_en,
  output logic             cpu_rst_n,
  output logic             busy,
  output logic             done,
  output logic [2:0]       stop_cause,
  output logic             cmd_err,
  output logic [CYC_W-1:0] cycle_count,
  output logic [1:0]       dbg_state
);

  localparam int RC_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int RS_W = $clog2(RST_CYCLES + 1);
  localparam logic [RC_W-1:0] TIMEOUT_V = RC_W'(TIMEOUT);
  localparam logic [RS_W-1:0] RST_LAST  = RS_W'(RST_CYCLES - 1);

  ctrl_state_e       state_q, state_d;
  stop_cause_e       cause_q, cause_d;
  logic              first_q;
  logic [RC_W-1:0]   run_cnt_q;
  logic [REG_W-1:0]  remaining_q;
  logic              bp_en_q;
  logic [REG_W-1:0]  bp_addr_q;
  logic [RS_W-1:0]   rst_cnt_q;
  logic              done_q, err_q, rel_q;
  logic              count_clr;

  cmd_op_e op;
  logic    executing, cmd_fire, stop_now, step_last;
  logic    hit_halt, hit_break, hit_user, hit_timeout;

  assign op        = cmd_op_e'(cmd_op);
  assign executing = (state_q == CTRL_RUN) || (state_q == CTRL_STEP);
  assign cmd_ready = (state_q != CTRL_CPU_RST);
  assign cmd_fire  = cmd_valid && cmd_ready;

  // The first cycle ignores the breakpoint so a run can resume from it.
  assign hit_halt    = cpu_halted;
  assign hit_break   = bp_en_q && (cpu_pc == bp_addr_q) && !first_q;
  assign hit_user    = cmd_fire && (op == CMD_STOP);
  assign hit_timeout = (state_q == CTRL_RUN) && (TIMEOUT != 0) && (run_cnt_q == TIMEOUT_V);
  assign stop_now    = executing && (hit_halt || hit_break || hit_user || hit_timeout);

  assign cpu_en    = executing && !stop_now;
  assign step_last = (state_q == CTRL_STEP) && cpu_en && (remaining_q == REG_W'(1));

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    count_clr = 1'b0;
    unique case (state_q)
      CTRL_IDLE: begin
        if (cmd_fire) begin
          if (op == CMD_RUN) begin
            state_d = CTRL_RUN;
            cause_d = STOP_NONE;
          end else if (op == CMD_STEP) begin
            state_d = CTRL_STEP;
            cause_d = STOP_NONE;
          end else if (op == CMD_RESET_CPU) begin
            state_d = CTRL_CPU_RST;
          end
        end
      end
      CTRL_RUN, CTRL_STEP: begin
        if (stop_now) begin
          state_d = CTRL_IDLE;
          cause_d = hit_halt  ? STOP_HALT  :
                    hit_break ? STOP_BREAK :
                    hit_user  ? STOP_USER  : STOP_TIMEOUT;
        end else if (step_last) begin
          state_d = CTRL_IDLE;
          cause_d = STOP_STEP_DONE;
        end
      end
      CTRL_CPU_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d   = CTRL_IDLE;
          cause_d   = STOP_NONE;
          count_clr = 1'b1;
        end
      end
      default: state_d = CTRL_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= CTRL_IDLE;
      cause_q     <= STOP_NONE;
      first_q     <= 1'b0;
      run_cnt_q   <= '0;
      remaining_q <= '0;
      bp_en_q     <= 1'b0;
      bp_addr_q   <= '0;
      rst_cnt_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rel_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      first_q <= (state_q == CTRL_IDLE) &&
                 ((state_d == CTRL_RUN) || (state_d == CTRL_STEP));
      done_q  <= (state_q != CTRL_IDLE) && (state_d == CTRL_IDLE);
      err_q   <= executing && cmd_fire && (op != CMD_STOP);
      rel_q   <= 1'b1;

      if (state_q == CTRL_IDLE) begin
        run_cnt_q <= '0;
      end else if ((state_q == CTRL_RUN) && cpu_en && (run_cnt_q != '1)) begin
        run_cnt_q <= run_cnt_q + RC_W'(1);
      end

      if ((state_q == CTRL_IDLE) && cmd_fire && (op == CMD_STEP)) begin
        remaining_q <= step_count(cmd_arg);
      end else if ((state_q == CTRL_STEP) && cpu_en) begin
        remaining_q <= remaining_q - REG_W'(1);
      end

      if ((state_q == CTRL_IDLE) && cmd_fire && (op == CMD_SET_BP)) begin
        bp_addr_q <= cmd_arg;
        bp_en_q   <= 1'b1;
      end else if ((state_q == CTRL_IDLE) && cmd_fire && (op == CMD_CLR_BP)) begin
        bp_en_q <= 1'b0;
      end

      rst_cnt_q <= (state_q == CTRL_CPU_RST) ? rst_cnt_q + RS_W'(1) : '0;
    end
  end

  sat_counter #(.W(CYC_W)) u_cycle_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .en    (cpu_en),
    .clr   (count_clr),
    .count (cycle_count)
  );

  assign busy       = (state_q != CTRL_IDLE);
  assign done       = done_q;
  assign cmd_err    = err_q;
  assign stop_cause = cause_q;
  assign cpu_rst_n  = rel_q && (state_q != CTRL_CPU_RST);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a toy pc-counting cpu, a transaction-level outcome model
// that expands each command into a per-cycle expected trace, and a negedge comparator.
module tb_cpu_run_ctrl;
  import cpu_run_ctrl_pkg::*;

  localparam int CYC_W      = 32;
  localparam int TIMEOUT    = 8;
  localparam int RST_CYCLES = 2;
  localparam int EW         = 6 + 3 + CYC_W;
  localparam longint INF    = 64'd1 << 40;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [REG_W-1:0] cmd_arg;
  logic             cpu_halted;
  logic [REG_W-1:0] cpu_pc;
  logic             cpu_en, cpu_rst_n, busy, done, cmd_err;
  logic [2:0]       stop_cause;
  logic [CYC_W-1:0] cycle_count;
  logic [1:0]       dbg_state;

  cpu_run_ctrl #(.CYC_W(CYC_W), .TIMEOUT(TIMEOUT), .RST_CYCLES(RST_CYCLES)) dut (
    .CLK(CLK), .RST_N(RST_N), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cpu_halted(cpu_halted), .cpu_pc(cpu_pc),
    .cpu_en(cpu_en), .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done),
    .stop_cause(stop_cause), .cmd_err(cmd_err), .cycle_count(cycle_count),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / toy cpu ----------------
  always #5 CLK = ~CLK;

  logic [REG_W-1:0] halt_at;
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N)          cpu_pc <= '0;
    else if (!cpu_rst_n) cpu_pc <= '0;
    else if (cpu_en)     cpu_pc <= cpu_pc + 1;
  end
  assign cpu_halted = (cpu_pc >= halt_at);

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  // Model state: what the controller and cpu must look like between commands.
  longint      m_pc, m_cycles;
  logic [2:0]  m_cause;
  logic        m_bp_en;
  longint      m_bp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e, a;
      e = exp_q.pop_front();
      a = {cpu_rst_n, cmd_ready, cpu_en, busy, done, cmd_err, stop_cause, cycle_count};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL trace t=%0t actual{rstn,rdy,en,busy,done,err,cause,cnt}=%b_%h required=%b_%h",
                 $time, a[EW-1:EW-9], a[CYC_W-1:0], e[EW-1:EW-9], e[CYC_W-1:0]);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [REG_W-1:0] arg);
    cmd_valid = v;
    cmd_op    = op;
    cmd_arg   = arg;
  endtask

  task automatic push(input logic rn, input logic rdy, input logic en, input logic bsy,
                      input logic dn, input logic er, input logic [2:0] cs, input longint cc);
    exp_q.push_back({rn, rdy, en, bsy, dn, er, cs, cc[CYC_W-1:0]});
  endtask

  // Outcome of a RUN/STEP: n instructions executed, the cause, and busy cycle count.
  function automatic void resolve(input logic is_step, input longint h, input longint b,
                                  input longint u, input longint t, input longint k,
                                  output longint n, output logic [2:0] cause, output int len);
    longint m;
    m = h;
    if (b < m) m = b;
    if (u < m) m = u;
    if (t < m) m = t;
    if (is_step && k <= m) begin
      n = k; cause = STOP_STEP_DONE; len = int'(k);
    end else begin
      n = m;
      cause = (h == m) ? STOP_HALT : (b == m) ? STOP_BREAK : (u == m) ? STOP_USER : STOP_TIMEOUT;
      len = int'(m) + 1;
    end
  endfunction

  // s: busy-cycle index at which STOP is presented (0 = none);
  // e: busy-cycle index at which a stray RUN is presented (0 = none).
  task automatic exec_txn(input logic [2:0] op, input logic [REG_W-1:0] arg,
                          input int s_in, input int e_in);
    longint h, b, t, k, n, base;
    logic [2:0] cause;
    int len, s, e;
    s = s_in;
    e = e_in;
    base = m_cycles;
    push(1, 1, 0, 0, 0, 0, m_cause, base);
    drive(1, op, arg);
    if (op == CMD_RUN || op == CMD_STEP) begin
      h = (longint'(halt_at) > m_pc) ? longint'(halt_at) - m_pc : 0;
      b = (m_bp_en && m_bp > m_pc) ? m_bp - m_pc : INF;
      t = (op == CMD_RUN && TIMEOUT != 0) ? longint'(TIMEOUT) : INF;
      k = (arg == 0) ? 1 : longint'(arg);
      resolve(op == CMD_STEP, h, b, INF, t, k, n, cause, len);
      if (s >= 1 && s <= len) resolve(op == CMD_STEP, h, b, longint'(s - 1), t, k, n, cause, len);
      else s = 0;
      if (e > len || e == s) e = 0;
      for (int c = 1; c <= len; c++)
        push(1, 1, c <= n, 1, 0, (e != 0) && (c == e + 1), STOP_NONE,
             base + ((longint'(c - 1) < n) ? longint'(c - 1) : n));
      push(1, 1, 0, 0, 1, (e != 0) && (len + 1 == e + 1), cause, base + n);
      step();
      for (int c = 1; c <= len + 1; c++) begin
        if (c == s)      drive(1, CMD_STOP, '0);
        else if (c == e) drive(1, CMD_RUN, REG_W'($urandom_range(0, 9)));
        else             drive(0, CMD_NOP, '0);
        step();
      end
      m_pc     += n;
      m_cycles += n;
      m_cause   = cause;
    end else if (op == CMD_RESET_CPU) begin
      for (int c = 1; c <= RST_CYCLES; c++) push(0, 0, 0, 1, 0, 0, m_cause, base);
      push(1, 1, 0, 0, 1, 0, STOP_NONE, 0);
      step();
      drive(0, CMD_NOP, '0);
      repeat (RST_CYCLES + 1) step();
      m_pc = 0; m_cycles = 0; m_cause = STOP_NONE;
    end else begin
      step();
      if (op == CMD_SET_BP) begin m_bp_en = 1'b1; m_bp = longint'(arg); end
      if (op == CMD_CLR_BP) m_bp_en = 1'b0;
    end
    drive(0, CMD_NOP, '0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    RST_N = 1'b0;
    halt_at = '1;
    drive(0, CMD_NOP, '0);
    m_pc = 0; m_cycles = 0; m_cause = STOP_NONE; m_bp_en = 0; m_bp = 0;
    #1;
    chk("rst_cpu_rst_n", cpu_rst_n, 0);
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_busy_done_err", {busy, done, cmd_err}, 0);
    chk("rst_cause", stop_cause, STOP_NONE);
    chk("rst_count", cycle_count, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_state", dbg_state, CTRL_IDLE);
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST_N = 1'b1;
    #1 chk("rst_rel_hold", cpu_rst_n, 0);
    step();
    chk("rst_rel_next", cpu_rst_n, 1);
    chk("rst_rel_en", cpu_en, 0);

    // Run until halt after 3 instructions.
    halt_at = 3;
    exec_txn(CMD_RUN, '0, 0, 0);
    chk("halt_count", cycle_count, 3);
    chk("halt_cause", stop_cause, STOP_HALT);
    chk("halt_pc", cpu_pc, 3);

    halt_at = '1;
    exec_txn(CMD_RESET_CPU, '0, 0, 0);
    chk("rstcpu_count", cycle_count, 0);
    chk("rstcpu_pc", cpu_pc, 0);

    exec_txn(CMD_STEP, 2, 0, 0);
    chk("step2_pc", cpu_pc, 2);
    chk("step2_cause", stop_cause, STOP_STEP_DONE);
    exec_txn(CMD_STEP, 0, 0, 0);
    chk("step0_pc", cpu_pc, 3);

    exec_txn(CMD_RESET_CPU, '0, 0, 0);
    exec_txn(CMD_SET_BP, 5, 0, 0);
    exec_txn(CMD_RUN, '0, 0, 0);
    chk("bp_pc", cpu_pc, 5);
    chk("bp_cause", stop_cause, STOP_BREAK);
    chk("bp_count", cycle_count, 5);
    exec_txn(CMD_RUN, '0, 3, 0);
    chk("user_pc", cpu_pc, 7);
    chk("user_cause", stop_cause, STOP_USER);

    exec_txn(CMD_CLR_BP, '0, 0, 0);
    exec_txn(CMD_RUN, '0, 0, 2);
    chk("timeout_pc", cpu_pc, 15);
    chk("timeout_cause", stop_cause, STOP_TIMEOUT);

    for (int i = 0; i < 40; i++) begin
      int r, s, e;
      logic [2:0] op;
      logic [REG_W-1:0] arg;
      r = $urandom_range(0, 9);
      op = (r <= 2) ? CMD_RUN : (r <= 4) ? CMD_STEP : (r == 5) ? CMD_SET_BP :
           (r == 6) ? CMD_CLR_BP : (r == 7) ? CMD_RESET_CPU : (r == 8) ? CMD_NOP : CMD_STOP;
      arg = (op == CMD_SET_BP) ? REG_W'(m_pc + $urandom_range(0, 9)) : REG_W'($urandom_range(0, 6));
      halt_at = ($urandom_range(0, 2) == 0) ? REG_W'(m_pc + $urandom_range(0, 10)) : '1;
      s = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 10)) : 0;
      e = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : 0;
      exec_txn(op, arg, s, e);
      chk("rand_pc", cpu_pc, REG_W'(m_pc));
    end

    // Asynchronous reset in the middle of a run.
    halt_at = '1;
    drive(1, CMD_RUN, '0);
    step();
    drive(0, CMD_NOP, '0);
    step();
    step();
    #2 RST_N = 1'b0;
    #1;
    chk("async_en", cpu_en, 0);
    chk("async_busy", busy, 0);
    chk("async_rst_n", cpu_rst_n, 0);
    chk("async_count", cycle_count, 0);
    @(negedge CLK) RST_N = 1'b1;
    step();
    chk("async_rel", cpu_rst_n, 1);
    m_pc = 0; m_cycles = 0; m_cause = STOP_NONE; m_bp_en = 0; m_bp = 0;
    halt_at = 2;
    exec_txn(CMD_RUN, '0, 0, 0);
    chk("recover_pc", cpu_pc, 2);
    chk("recover_cause", stop_cause, STOP_HALT);

    step();
    chk("trace_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
